// File: rtl/stage_4_mem.sv
// Memory-access stage: req/ack data-memory port, load extraction, store lane steering, timeout.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing them to alignment.
module stage_4_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd_num,
  input  logic        i_op_type,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  output logic        stall,
  output logic        valid,
  output logic [31:0] mem_out,
  output logic [31:0] alu_out,
  output logic [4:0]  rd_num,
  output logic        op_type,
  output logic        bus_err,
  output logic        misalign
);

  // state | meaning
  // IDLE  | accept instructions from execute
  // WAIT  | memory request outstanding, upstream stalled
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_op;
  logic        r_st;
  logic [15:0] r_cnt;

  logic        w_wait;
  logic        w_in_mem;
  logic        w_is_b;
  logic        w_is_h;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;

  assign w_wait   = (r_state == WAIT);
  assign w_in_mem = i_op_type | i_is_store;
  // Reserved funct3 codes fall through to word access.
  assign w_is_b   = (r_funct3[1:0] == 2'b00);
  assign w_is_h   = (r_funct3[1:0] == 2'b01);

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = i_mem_rdata[7:0];
      2'd1: w_byte = i_mem_rdata[15:8];
      2'd2: w_byte = i_mem_rdata[23:16];
      2'd3: w_byte = i_mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    if (w_is_b) begin
      w_load  = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
      w_wdata = {4{r_wdata[7:0]}};
      w_be    = 4'b0001 << r_addr[1:0];
    end else if (w_is_h) begin
      w_load  = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      w_wdata = {2{r_wdata[15:0]}};
      w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      w_load  = i_mem_rdata;
      w_wdata = r_wdata;
      w_be    = 4'b1111;
    end
  end

  // Bus outputs are quiet outside WAIT so an abandoned request leaves nothing driven.
  assign o_mem_req   = w_wait;
  assign stall       = w_wait;
  assign o_mem_we    = w_wait & r_st;
  assign o_mem_addr  = w_wait ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_wdata = w_wait ? w_wdata : 32'h0;
  assign o_mem_be    = w_wait ? w_be : 4'h0;

`ifdef MISALIGN_TRAP_EN
  logic w_in_mis;
  assign w_in_mis = (i_funct3[1:0] == 2'b01) ? i_alu_out[0] :
                    (i_funct3[1:0] == 2'b00) ? 1'b0 : (i_alu_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'h0;
      r_rd     <= 5'h0;
      r_op     <= 1'b0;
      r_st     <= 1'b0;
      r_cnt    <= 16'h0;
      valid    <= 1'b0;
      mem_out  <= 32'h0;
      alu_out  <= 32'h0;
      rd_num   <= 5'h0;
      op_type  <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt <= 16'h0;
          if (!i_valid) begin
            valid <= 1'b0;
          end else if (!w_in_mem) begin
            valid   <= 1'b1;
            alu_out <= i_alu_out;
            rd_num  <= i_rd_num;
            op_type <= i_op_type;
            mem_out <= 32'h0;
`ifdef MISALIGN_TRAP_EN
          end else if (w_in_mis) begin
            valid    <= 1'b1;
            misalign <= 1'b1;
            alu_out  <= i_alu_out;
            rd_num   <= 5'h0;
            op_type  <= i_op_type;
            mem_out  <= 32'h0;
`endif
          end else begin
            r_addr   <= i_alu_out;
            r_wdata  <= i_rs2;
            r_funct3 <= i_funct3;
            r_rd     <= i_rd_num;
            r_op     <= i_op_type;
            r_st     <= i_is_store;
            valid    <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_ack) begin
            valid   <= 1'b1;
            alu_out <= r_addr;
            op_type <= r_op;
            rd_num  <= r_st ? 5'h0 : r_rd;
            mem_out <= r_st ? 32'h0 : w_load;
            r_state <= IDLE;
          end else if (r_cnt == TO_LAST) begin
            valid   <= 1'b1;
            bus_err <= 1'b1;
            alu_out <= r_addr;
            op_type <= r_op;
            rd_num  <= 5'h0;
            mem_out <= 32'h0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'h1;
            valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Randomized bench for stage_4_mem against an arithmetic model of the load/store/timeout rules.
module tb_stage_4_mem;
  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_alu_out = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rd_num = '0;
  logic        i_op_type = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_mem_req, o_mem_we, stall, valid, op_type, bus_err, misalign;
  logic [31:0] o_mem_addr, o_mem_wdata, mem_out, alu_out;
  logic [3:0]  o_mem_be;
  logic [4:0]  rd_num;

  int n_chk = 0;
  int n_err = 0;

  stage_4_mem #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_alu_out(i_alu_out),
    .i_rs2(i_rs2), .i_rd_num(i_rd_num), .i_op_type(i_op_type), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .stall(stall), .valid(valid),
    .mem_out(mem_out), .alu_out(alu_out), .rd_num(rd_num), .op_type(op_type),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int o = int'(a % 4);
    int sz = m_size(f3);
    logic [31:0] v;
    if (sz == 1) begin
      v = (d >> (8 * o)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (d >> (16 * (o / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
    end else v = d;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int o = int'(a % 4);
    if (m_size(f3) == 1) return 4'(1 << o);
    if (m_size(f3) == 2) return 4'(3 << ((o / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // ack_at: WAIT cycle (1-based) in which ack is presented; beyond TO means no ack.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input bit op, input bit st, input logic [2:0] f3,
                        input int ack_at, input logic [31:0] rdata);
    bit is_mem = op | st;
    bit done = 0;
    int w = 1;
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_out = alu; i_rs2 = rs2; i_rd_num = rd;
    i_op_type = op; i_is_store = st; i_funct3 = f3;
    @(negedge i_clk);
    i_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (is_mem && m_mis(f3, alu)) begin
      chk("mis_pulse", misalign, 1);
      chk("mis_valid", valid, 1);
      chk("mis_rd", rd_num, 0);
      chk("mis_req", o_mem_req, 0);
      is_mem = 0;
      done = 1;
    end
`endif
    if (!is_mem && !done) begin
      chk("alu_valid", valid, 1);
      chk("alu_out", alu_out, alu);
      chk("alu_rd", rd_num, rd);
      chk("alu_op", op_type, op);
      chk("alu_memout", mem_out, 0);
      chk("alu_req", o_mem_req, 0);
      chk("alu_stall", stall, 0);
    end else if (is_mem) begin
      while (1) begin
        chk("wait_req", o_mem_req, 1);
        chk("wait_stall", stall, 1);
        chk("wait_valid", valid, 0);
        chk("wait_addr", o_mem_addr, alu & 32'hFFFF_FFFC);
        chk("wait_we", o_mem_we, st);
        if (st) begin
          chk("wait_be", o_mem_be, m_be(f3, alu));
          chk("wait_wdata", o_mem_wdata, m_wdata(f3, rs2));
        end
        // upstream noise while stalled must be ignored
        i_valid = 1'($urandom_range(0, 1)); i_alu_out = $urandom; i_op_type = 1'($urandom);
        if (w == ack_at) begin
          i_mem_ack = 1'b1; i_mem_rdata = rdata; done = 1;
        end else i_mem_rdata = $urandom;
        @(negedge i_clk);
        i_mem_ack = 1'b0; i_valid = 1'b0;
        if (done || w >= TO) break;
        w++;
      end
      chk("done_req", o_mem_req, 0);
      chk("done_stall", stall, 0);
      chk("done_valid", valid, 1);
      chk("done_buserr", bus_err, (ack_at > TO) ? 1 : 0);
      chk("done_rd", rd_num, (st || ack_at > TO) ? 5'd0 : rd);
      chk("done_memout", mem_out, (st || ack_at > TO) ? 32'h0 : m_load(f3, alu, rdata));
      chk("done_op", op_type, op);
    end
    chk("misalign_idle", misalign, 0);
    @(negedge i_clk);
    chk("pulse_valid", valid, 0);
    chk("pulse_buserr", bus_err, 0);
    chk("pulse_misalign", misalign, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_memout", mem_out, 0);
    chk("rst_rd", rd_num, 0);
    chk("rst_be", o_mem_be, 0);
    chk("rst_buserr", bus_err, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op(32'h1234_5678, 32'h0, 5'd7, 0, 0, 3'd0, 1, 32'h0);
    run_op(32'h0000_0103, 32'h0, 5'd3, 1, 0, 3'd0, 3, 32'h80FF_0011);
    run_op(32'h0000_0103, 32'h0, 5'd3, 1, 0, 3'd4, 3, 32'h80FF_0011);
    run_op(32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 0, 1, 3'd1, 1, 32'h0);
    run_op(32'h0000_0040, 32'h0, 5'd5, 1, 0, 3'd2, TO + 1, 32'h0);
    run_op(32'h0000_0040, 32'h0, 5'd5, 1, 0, 3'd2, TO, 32'hCAFE_F00D);
    run_op(32'h0000_0301, 32'h0, 5'd4, 1, 0, 3'd2, 1, 32'h1357_9BDF);

    // async reset in the middle of an outstanding request
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_out = 32'h400; i_op_type = 1'b1; i_is_store = 1'b0;
    i_funct3 = 3'd2; i_rd_num = 5'd2;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("pre_rst_req", o_mem_req, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_req", o_mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_valid", valid, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op(32'hA5A5_0001, 32'h0, 5'd31, 0, 0, 3'd0, 1, 32'h0);

    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 2);
      run_op($urandom, $urandom, 5'($urandom), kind == 1, kind == 2,
             3'($urandom_range(0, 7)), $urandom_range(1, TO + 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/stage_4_mem.md
Name: stage_4_mem

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. It is the producer side of the writeback interface: it generates mem_out, rd_num, alu_out and op_type for stage 5.
- Sits between the execute stage and writeback.
- Drives a req/ack data-memory port. Performs load byte/half extraction with sign or zero extension, and store byte-lane steering.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256, cycles to wait for i_mem_ack before aborting with bus error. Range 1..65535.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute stage presents an instruction
- i_alu_out  in  32  ALU result; effective address for loads and stores
- i_rs2  in  32  store data
- i_rd_num  in  5  destination register
- i_op_type  in  1  0 = ALU result, 1 = load
- i_is_store  in  1  store instruction (i_op_type = 0 when set)
- i_funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_mem_ack  in  1  memory completes the current request
- i_mem_rdata  in  32  read word, valid with i_mem_ack
- o_mem_req  out  1  request active
- o_mem_we  out  1  write request
- o_mem_addr  out  32  word address, bits [1:0] always 0
- o_mem_wdata  out  32  lane-replicated store data
- o_mem_be  out  4  byte enables
- stall  out  1  upstream must hold its outputs
- valid  out  1  writeback bundle valid
- mem_out  out  32  extended load data
- alu_out  out  32  registered i_alu_out
- rd_num  out  5  destination register; 0 for stores and aborted operations
- op_type  out  1  registered i_op_type
- bus_err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse on misaligned access (see Optional Feature)

Behaviour:
- Reset (async, i_rst_n = 0): state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops o_mem_req immediately. The memory must tolerate an abandoned request.
- FSM states: IDLE, WAIT.
- IDLE, i_valid = 0:
  - valid <= 0.
- IDLE, i_valid = 1, not a memory op:
  - Next cycle: valid = 1; alu_out, rd_num and op_type are registered copies of the inputs; mem_out = 0.
  - Latency 1 cycle.
- IDLE, i_valid = 1, load or store:
  - Latch address, funct3, rd_num, op_type and store data. Go to WAIT; valid <= 0.
  - Upstream may advance this cycle because the instruction has been consumed.
- WAIT:
  - o_mem_req = 1; o_mem_addr/we/be/wdata come from latched values and stay stable until ack.
  - stall = 1, combinational, (state == WAIT).
  - i_valid is ignored.
  - i_mem_ack = 1: next cycle valid = 1; load data is extracted from i_mem_rdata; return to IDLE; o_mem_req = 0.
  - Ack is accepted on the first WAIT cycle (minimum memory-op latency 2 cycles).
- Load extraction (offset = addr[1:0]):
  - B/BU: byte at lane offset.
  - H/HU: half at lane offset[1].
  - W: full word.
  - B and H sign-extend; BU and HU zero-extend.
- Store steering:
  - SB: be = 4'b0001 << offset; wdata = byte replicated in all 4 lanes.
  - SH: be = 4'b0011 << (offset[1]*2); wdata = half replicated in both halves.
  - SW: be = 4'b1111.
  - Stores complete with valid = 1 and rd_num = 0.
- Reserved funct3 values are treated as W.
- Timeout:
  - Counter increments each WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop request, pulse bus_err, valid = 1 with rd_num = 0 and mem_out = 0, return to IDLE.
  - An ack arriving in the same cycle the timeout reaches its limit wins; no error is raised.
- valid is a single-cycle pulse per instruction; there is no downstream backpressure.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses (H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 0) issue no request and do not enter WAIT.
  - Next cycle: misalign = 1 for one cycle, valid = 1, rd_num = 0, mem_out = 0.
- Not defined:
  - misalign is tied 0.
  - Misaligned addresses are forced to alignment: addr[0] cleared for halves, addr[1:0] cleared for words. The access then proceeds normally.

Test Plan:
- ALU pass-through: i_valid = 1, i_op_type = 0, i_alu_out = 0x1234_5678, i_rd_num = 7 -> next cycle valid = 1, alu_out = 0x12345678, rd_num = 7, stall = 0, o_mem_req never asserted.
- LB sign extension: addr 0x103, rdata 0x80FF_0011, ack after 3 WAIT cycles -> o_mem_addr = 0x100, stall high 3 cycles, mem_out = 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- SH: addr 0x202, i_rs2 = 0xDEAD_BEEF, immediate ack -> o_mem_we = 1, be = 4'b1100, wdata = 0xBEEF_BEEF, valid with rd_num = 0.
- Timeout: TIMEOUT_CYCLES = 4, never ack -> o_mem_req high for 4 cycles, bus_err pulse, valid with rd_num = 0; ack in cycle 4 instead -> no bus_err, data returned.
- Reset mid-WAIT: assert i_rst_n = 0 during WAIT -> o_mem_req, stall and valid drop asynchronously; after release, an ALU op passes through in 1 cycle.
- MISALIGN_TRAP_EN: LW at addr 0x301 -> no o_mem_req, misalign pulse, valid with rd_num = 0. Without the macro: request issued to 0x300.
